id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 32-bit 5-stage MIPS pipeline; sits directly downstream of the register file.
- Captures the register-file read operands, decoded control and immediate each cycle.
- Resolves the same-cycle WB-to-ID write/read hazard via bypass.
- Detects load-use hazards, inserts a bubble into EX and supports hold (stall) and flush.

---
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: WB-to-ID operand bypass, load-use bubble, hold and flush.
// Optional bubble/hold performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_imm,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic [3:0]    id_alu_op,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_write_reg,
    input  logic [DW-1:0] wb_write_data,
    input  logic          flush,
    input  logic          ex_hold,
    output logic          stall_up,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_alu_src,
    output logic [3:0]    ex_alu_op,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   hold_cnt
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dest;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic [3:0]    alu_op;
    } ex_t;

    ex_t           ex_q, ex_d;
    logic [DW-1:0] op_a, op_b;
    logic          lu;

    // r0 is hard-wired zero, so a matching WB write to r0 is never forwarded.
    always_comb begin
        op_a = rd_data1;
        if (id_rs == '0) begin
            op_a = '0;
        end else if (wb_reg_write && (wb_write_reg == id_rs)) begin
            op_a = wb_write_data;
        end
        op_b = rd_data2;
        if (id_rt == '0) begin
            op_b = '0;
        end else if (wb_reg_write && (wb_write_reg == id_rt)) begin
            op_b = wb_write_data;
        end
    end

    assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) && id_valid &&
                ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));

    assign stall_up = ex_hold | (lu & ~flush);

    always_comb begin
        ex_d = ex_q;
        if (ex_hold) begin
            ex_d = ex_q;
        end else if (flush || lu || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid      = 1'b1;
            ex_d.pc         = id_pc;
            ex_d.a          = op_a;
            ex_d.b          = op_b;
            ex_d.imm        = id_imm;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.dest       = id_reg_dst ? id_rd : id_rt;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.alu_src    = id_alu_src;
            ex_d.alu_op     = id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_a          = ex_q.a;
    assign ex_b          = ex_q.b;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, hold_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (lu && !flush && !ex_hold) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (ex_hold) begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`else
    assign bubble_cnt = '0;
    assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: bypass vector table, hand-written stall/flush/hold/reset
// sequences, then randomized traffic against a rule-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, rd_data1, rd_data2, wb_write_data;
    logic [4:0]  id_rs, id_rt, id_rd, wb_write_reg;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write, flush, ex_hold;
    logic        stall_up, ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [31:0] bubble_cnt, hold_cnt;

    int errors = 0;
    int checks = 0;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
        .ex_hold(ex_hold), .stall_up(stall_up), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic dst, input logic mr);
        id_valid      = 1'b1;
        id_pc         = pc;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
        id_reg_dst    = dst;
        id_mem_read   = mr;
        id_mem_to_reg = mr;
        id_reg_write  = 1'b1;
        id_mem_write  = 1'b0;
        id_alu_src    = mr;
        id_alu_op     = 4'd2;
        id_imm        = 32'h0000_0004;
    endtask

    // Reference EX-slot contents, derived from the stage's stated rules.
    typedef struct {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, dest;
        logic        rw, mr, mw, m2r, asrc;
        logic [3:0]  op;
    } ex_m_t;

    ex_m_t       m;
    logic [31:0] m_bub, m_hold;

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (wb_reg_write && wb_write_reg == idx) return wb_write_data;
        return rf;
    endfunction

    function automatic logic model_lu();
        return m.valid && m.mr && m.rt != 5'd0 && id_valid && (m.rt == id_rs || m.rt == id_rt);
    endfunction

    function automatic ex_m_t model_next();
        ex_m_t n;
        n = '{default: '0};
        if (ex_hold) return m;
        if (flush || model_lu() || !id_valid) return n;
        n.valid = 1'b1;              n.pc = id_pc;
        n.a = operand(id_rs, rd_data1);
        n.b = operand(id_rt, rd_data2);
        n.imm = id_imm;              n.rs = id_rs;            n.rt = id_rt;
        n.dest = id_reg_dst ? id_rd : id_rt;
        n.rw = id_reg_write;         n.mr = id_mem_read;      n.mw = id_mem_write;
        n.m2r = id_mem_to_reg;       n.asrc = id_alu_src;     n.op = id_alu_op;
        return n;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, ex_valid, m.valid);
        chk({tag, ".pc"}, ex_pc, m.pc);
        chk({tag, ".a"}, ex_a, m.a);
        chk({tag, ".b"}, ex_b, m.b);
        chk({tag, ".imm"}, ex_imm, m.imm);
        chk({tag, ".rs"}, ex_rs, m.rs);
        chk({tag, ".rt"}, ex_rt, m.rt);
        chk({tag, ".dest"}, ex_dest, m.dest);
        chk({tag, ".ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src},
            {m.rw, m.mr, m.mw, m.m2r, m.asrc});
        chk({tag, ".alu_op"}, ex_alu_op, m.op);
        chk({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
        chk({tag, ".hold_cnt"}, hold_cnt, m_hold);
    endtask

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        dst;
        logic [31:0] d1, d2;
        logic        wbw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic [31:0] exp_a, exp_b;
        logic [4:0]  exp_dest;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5'd1, 5'd3, 5'd7, 1'b1, 32'd16, 32'd6, 1'b0, 5'd0, 32'd0, 32'd16, 32'd6, 5'd7};
        vecs[1] = '{5'd1, 5'd3, 5'd7, 1'b1, 32'd16, 32'd6, 1'b1, 5'd1, 32'd99, 32'd99, 32'd6, 5'd7};
        vecs[2] = '{5'd0, 5'd3, 5'd7, 1'b1, 32'd16, 32'd6, 1'b1, 5'd0, 32'd99, 32'd0, 32'd6, 5'd7};
        vecs[3] = '{5'd1, 5'd3, 5'd7, 1'b0, 32'd16, 32'd6, 1'b1, 5'd3, 32'd55, 32'd16, 32'd55, 5'd3};
        vecs[4] = '{5'd2, 5'd2, 5'd9, 1'b1, 32'd5, 32'd8, 1'b1, 5'd2, 32'd77, 32'd77, 32'd77, 5'd9};
        vecs[5] = '{5'd4, 5'd0, 5'd1, 1'b0, 32'd42, 32'd123, 1'b0, 5'd4, 32'd1, 32'd42, 32'd0, 5'd0};

        rst_n = 1'b0;
        set_id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        id_valid = 1'b0; rd_data1 = '0; rd_data2 = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        flush = 1'b0; ex_hold = 1'b0;
        #12;
        chk("reset.valid", ex_valid, 0);
        chk("reset.data", ex_pc | ex_a | ex_b | ex_imm, 0);
        chk("reset.ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                          ex_alu_op, ex_rs, ex_rt, ex_dest}, 0);
        chk("reset.cnt", bubble_cnt | hold_cnt, 0);
        chk("reset.stall_up", stall_up, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass table
        for (int i = 0; i < 6; i++) begin
            set_id(32'h100 + 32'(i * 4), vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].dst, 1'b0);
            rd_data1 = vecs[i].d1; rd_data2 = vecs[i].d2;
            wb_reg_write = vecs[i].wbw; wb_write_reg = vecs[i].wbr; wb_write_data = vecs[i].wbd;
            tick();
            chk($sformatf("vec%0d.a", i), ex_a, vecs[i].exp_a);
            chk($sformatf("vec%0d.b", i), ex_b, vecs[i].exp_b);
            chk($sformatf("vec%0d.dest", i), ex_dest, vecs[i].exp_dest);
            chk($sformatf("vec%0d.valid_rw", i), {ex_valid, ex_reg_write}, 2'b11);
        end
        wb_reg_write = 1'b0;

        // Load-use: lw rt=5, then add rs=5
        set_id(32'h200, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
        tick();
        chk("lu.lw_mem_read", ex_mem_read, 1);
        set_id(32'h204, 5'd5, 5'd3, 5'd7, 1'b1, 1'b0);
        #1 chk("lu.stall_up_n", stall_up, 1);
        tick();
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.bubble_ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src},
            0);
        chk("lu.bubble_pc", ex_pc, 0);
        chk("lu.stall_up_n1", stall_up, 0);
        tick();
        chk("lu.capture_valid", ex_valid, 1);
        chk("lu.capture_pc", ex_pc, 32'h204);
        chk("lu.capture_dest", ex_dest, 7);
        chk("lu.bubble_cnt", bubble_cnt, Perf ? 32'd1 : 32'd0);

        // Flush beats load-use
        set_id(32'h300, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
        tick();
        set_id(32'h304, 5'd5, 5'd3, 5'd7, 1'b1, 1'b0);
        flush = 1'b1;
        #1 chk("flush.stall_up", stall_up, 0);
        tick();
        chk("flush.bubble_valid", ex_valid, 0);
        flush = 1'b0;
        set_id(32'h40, 5'd2, 5'd3, 5'd8, 1'b1, 1'b0);
        rd_data1 = 32'd11;
        tick();
        chk("flush.next_valid", ex_valid, 1);
        chk("flush.next_pc", ex_pc, 32'h40);
        chk("flush.bubble_cnt", bubble_cnt, Perf ? 32'd1 : 32'd0);

        // Hold for three edges while ID changes, then async reset mid-hold
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h500 + 32'(i), 5'd6, 5'd7, 5'd9, 1'b0, 1'b1);
            rd_data1 = 32'hdead_0000 + 32'(i);
            #1 chk($sformatf("hold%0d.stall_up", i), stall_up, 1);
            tick();
            chk($sformatf("hold%0d.pc", i), ex_pc, 32'h40);
            chk($sformatf("hold%0d.a", i), ex_a, 32'd11);
            chk($sformatf("hold%0d.valid", i), ex_valid, 1);
        end
        chk("hold.hold_cnt", hold_cnt, Perf ? 32'd3 : 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.valid", ex_valid, 0);
        chk("areset.data", ex_pc | ex_a | ex_b | ex_imm, 0);
        chk("areset.cnt", bubble_cnt | hold_cnt, 0);
        chk("areset.stall_up_hold", stall_up, 1);
        ex_hold = 1'b0;
        #1 chk("areset.stall_up_free", stall_up, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        m = '{default: '0};
        m_bub = '0;
        m_hold = '0;
        for (int c = 0; c < 400; c++) begin
            ex_m_t nxt;
            logic  exp_stall;
            id_valid      = ($urandom_range(0, 3) != 0);
            id_pc         = $urandom;
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 31));
            id_imm        = $urandom;
            id_reg_write  = 1'($urandom);
            id_mem_read   = ($urandom_range(0, 2) == 0);
            id_mem_write  = 1'($urandom);
            id_mem_to_reg = 1'($urandom);
            id_alu_src    = 1'($urandom);
            id_reg_dst    = 1'($urandom);
            id_alu_op     = 4'($urandom);
            rd_data1      = $urandom;
            rd_data2      = $urandom;
            wb_reg_write  = 1'($urandom);
            wb_write_reg  = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            flush         = ($urandom_range(0, 7) == 0);
            ex_hold       = ($urandom_range(0, 7) == 0);
            #1;
            exp_stall = ex_hold || (model_lu() && !flush);
            chk($sformatf("rnd%0d.stall_up", c), stall_up, exp_stall);
            if (Perf && model_lu() && !flush && !ex_hold) m_bub = m_bub + 1;
            if (Perf && ex_hold) m_hold = m_hold + 1;
            nxt = model_next();
            tick();
            m = nxt;
            check_all($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
